com_to_mem_fsm_param: RTL and testbench



---
 rtl/com_to_mem_fsm_param_if.sv | 36 +++
 rtl/com_to_mem_fsm_param.sv | 266 ++++++++++++++++++++++++++
 tb/tb_com_to_mem_fsm_param.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/com_to_mem_fsm_param_if.sv
// ---------------------------------------------------------------------------
// com_to_mem_fsm_param_if
// Bundles the UART byte streams and the BRAM port used by the command
// controller.
//   rx_data/rx_valid   : received byte + one-cycle strobe (into controller)
//   tx_data/tx_valid   : byte offered to UART TX (out of controller)
//   tx_ready           : TX accepts when tx_valid && tx_ready
//   mem_addr/mem_wdata : BRAM address / write data (out of controller)
//   mem_we             : one-cycle write strobe
//   mem_rdata          : BRAM read data (into controller)
// master = controller side, slave = UART/BRAM side.
// ---------------------------------------------------------------------------
interface com_to_mem_fsm_param_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_rdata,
    output tx_data, tx_valid, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_rdata,
    input  tx_data, tx_valid, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/com_to_mem_fsm_param.sv
// ---------------------------------------------------------------------------
// com_to_mem_fsm_param
// Parses ASCII hex commands from a UART byte stream and drives a single-port
// BRAM:  p<addr><data> writes one word, r<addr> reads one word and replies
// with the word as uppercase hex followed by CR LF. Malformed commands are
// answered with "?" CR LF and leave the memory untouched.
// Ports:
//   clk      : system clock (rising edge)
//   rst_n    : asynchronous active-low reset
//   bus      : UART RX/TX and BRAM signals (master modport)
//   busy     : high whenever the FSM is not in IDLE
//   cmd_err  : one-cycle pulse when a command is rejected
// ---------------------------------------------------------------------------
module com_to_mem_fsm_param #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  com_to_mem_fsm_param_if.master        bus,
  output logic                          busy,
  output logic                          cmd_err
);

  localparam int ADDR_DIGITS = (ADDR_W + 3) / 4;
  localparam int DATA_DIGITS = (DATA_W + 3) / 4;
  localparam int TX_W        = DATA_DIGITS * 4;
  localparam int MAX_DIGITS  = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
  localparam int CNT_W       = $clog2(MAX_DIGITS + 1);
  localparam int LAT_W       = $clog2(READ_LATENCY + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_DIGITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_DIGITS - 1);
  localparam logic [CNT_W-1:0] DATA_CNT  = CNT_W'(DATA_DIGITS);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(READ_LATENCY);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_Q  = 8'h3F;

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_DATA, WRITE, READ_WAIT, TX_DIGIT, TX_CR, TX_LF, TX_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0] data_sh_q, data_sh_d;
  logic [TX_W-1:0]   tx_sh_q, tx_sh_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              cmd_err_q, cmd_err_d;

  // {valid, nibble}. '0'..'9' carry their value in the low nibble; letters
  // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46))
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'b0;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  logic [4:0]        dec;
  logic              handshake;
  logic              is_p, is_r;
  logic [ADDR_W-1:0] addr_shift;
  logic [DATA_W-1:0] data_shift;
  logic [TX_W-1:0]   tx_load;

  always_comb begin
    dec        = hex_decode(bus.rx_data);
    handshake  = tx_valid_q && bus.tx_ready;
    is_p       = (bus.rx_data == 8'h70) || (bus.rx_data == 8'h50);
    is_r       = (bus.rx_data == 8'h72) || (bus.rx_data == 8'h52);
    // Shift in the new nibble; excess high digits fall off the top.
    addr_shift = ADDR_W'({addr_sh_q, dec[3:0]});
    data_shift = DATA_W'({data_sh_q, dec[3:0]});
    // Zero-extend read data to a whole number of nibbles.
    tx_load    = TX_W'(bus.mem_rdata);

    state_d     = state_q;
    op_wr_d     = op_wr_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    tx_sh_d     = tx_sh_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    cmd_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid && (is_p || is_r)) begin
          op_wr_d   = is_p;
          cnt_d     = '0;
          addr_sh_d = '0;
          data_sh_d = '0;
          state_d   = GET_ADDR;
        end
      end

      GET_ADDR: begin
        if (bus.rx_valid) begin
          if (dec[4]) begin
            addr_sh_d = addr_shift;
            if (cnt_q == ADDR_LAST) begin
              cnt_d = '0;
              if (op_wr_q) begin
                state_d = GET_DATA;
              end else begin
                mem_addr_d = addr_shift;
                lat_d      = '0;
                state_d    = READ_WAIT;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cmd_err_d  = 1'b1;
            tx_data_d  = CH_Q;
            tx_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = TX_ERR;
          end
        end
      end

      GET_DATA: begin
        if (bus.rx_valid) begin
          if (dec[4]) begin
            data_sh_d = data_shift;
            if (cnt_q == DATA_LAST) begin
              cnt_d       = '0;
              mem_addr_d  = addr_sh_q;
              mem_wdata_d = data_shift;
              mem_we_d    = 1'b1;
              state_d     = WRITE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cmd_err_d  = 1'b1;
            tx_data_d  = CH_Q;
            tx_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = TX_ERR;
          end
        end
      end

      // mem_we is high for exactly this cycle.
      WRITE: state_d = IDLE;

      // Address is stable from the first READ_WAIT cycle; data is valid
      // READ_LATENCY cycles later and captured at the end of that cycle.
      READ_WAIT: begin
        if (lat_q == LAT_LAST) begin
          tx_data_d  = hex_char(tx_load[TX_W-1 -: 4]);
          tx_sh_d    = tx_load << 4;
          tx_valid_d = 1'b1;
          cnt_d      = CNT_W'(1);
          lat_d      = '0;
          state_d    = TX_DIGIT;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      // cnt_q counts digits already offered (including the one on tx_data).
      TX_DIGIT: begin
        if (handshake) begin
          if (cnt_q == DATA_CNT) begin
            tx_data_d = CH_CR;
            cnt_d     = '0;
            state_d   = TX_CR;
          end else begin
            tx_data_d = hex_char(tx_sh_q[TX_W-1 -: 4]);
            tx_sh_d   = tx_sh_q << 4;
            cnt_d     = cnt_q + 1'b1;
          end
        end
      end

      TX_ERR: begin
        if (handshake) begin
          tx_data_d = CH_CR;
          state_d   = TX_CR;
        end
      end

      TX_CR: begin
        if (handshake) begin
          tx_data_d = CH_LF;
          state_d   = TX_LF;
        end
      end

      TX_LF: begin
        if (handshake) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_wr_q     <= 1'b0;
      cnt_q       <= '0;
      lat_q       <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      tx_sh_q     <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      tx_sh_q     <= tx_sh_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign busy          = (state_q != IDLE);
  assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_com_to_mem_fsm_param.sv
// ---------------------------------------------------------------------------
// tb_com_to_mem_fsm_param
// Directed bench for com_to_mem_fsm_param. Two instances: dut0 with 16-bit
// address/data and READ_LATENCY=1, dut1 with 10-bit address, 12-bit data and
// READ_LATENCY=2. Each has a behavioural BRAM and a TX byte collector.
// ---------------------------------------------------------------------------
module tb_com_to_mem_fsm_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic busy0, cmd_err0, busy1, cmd_err1;

  com_to_mem_fsm_param_if #(.ADDR_W(16), .DATA_W(16)) bus0();
  com_to_mem_fsm_param_if #(.ADDR_W(10), .DATA_W(12)) bus1();

  com_to_mem_fsm_param #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0), .cmd_err(cmd_err0)
  );

  com_to_mem_fsm_param #(.ADDR_W(10), .DATA_W(12), .READ_LATENCY(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .cmd_err(cmd_err1)
  );

  // Behavioural BRAMs (read-first, registered read).
  logic [15:0] mem0 [0:65535];
  logic [15:0] rd0;
  logic [11:0] mem1 [0:1023];
  logic [11:0] rd1a, rd1b;

  initial begin
    for (int i = 0; i < 65536; i++) mem0[i] = '0;
    for (int i = 0; i < 1024; i++)  mem1[i] = '0;
  end

  always @(posedge clk) begin
    if (bus0.mem_we) mem0[bus0.mem_addr] <= bus0.mem_wdata;
    rd0 <= mem0[bus0.mem_addr];
    if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    rd1a <= mem1[bus1.mem_addr];
    rd1b <= rd1a;
  end
  assign bus0.mem_rdata = rd0;
  assign bus1.mem_rdata = rd1b;

  // Collectors, sampled on the falling edge.
  byte unsigned q0[$];
  byte unsigned q1[$];
  int we0 = 0, we1 = 0, err0 = 0, err1 = 0;

  always @(negedge clk) begin
    if (bus0.tx_valid && bus0.tx_ready) q0.push_back(bus0.tx_data);
    if (bus1.tx_valid && bus1.tx_ready) q1.push_back(bus1.tx_data);
    if (bus0.mem_we) we0++;
    if (bus1.mem_we) we1++;
    if (cmd_err0) err0++;
    if (cmd_err1) err1++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    if (sel == 0) begin bus0.rx_data = b; bus0.rx_valid = 1'b1; end
    else          begin bus1.rx_data = b; bus1.rx_valid = 1'b1; end
    step();
    bus0.rx_valid = 1'b0;
    bus1.rx_valid = 1'b0;
    $display("rx[%0d] byte 0x%02h", sel, b);
  endtask

  task automatic send_str(input int sel, input string s);
    for (int i = 0; i < s.len(); i++) send_byte(sel, s[i]);
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  task automatic wait_bytes(input int sel, input int n);
    for (int i = 0; i < 200; i++) begin
      if (qsize(sel) >= n) break;
      step();
    end
    check("reply length", qsize(sel), n);
  endtask

  task automatic check_bytes(input int sel, input string s);
    for (int i = 0; i < s.len(); i++) begin
      logic [31:0] obs;
      obs = 32'hFFFF_FFFF;
      if (sel == 0 && i < q0.size()) obs = {24'h0, q0[i]};
      if (sel == 1 && i < q1.size()) obs = {24'h0, q1[i]};
      $display("tx[%0d] byte %0d 0x%02h", sel, i, obs[7:0]);
      check($sformatf("tx[%0d] byte %0d", sel, i), obs, {24'h0, s[i]});
    end
  endtask

  int we_before;
  logic [7:0] held;

  initial begin
    bus0.rx_data = '0; bus0.rx_valid = 1'b0; bus0.tx_ready = 1'b1;
    bus1.rx_data = '0; bus1.rx_valid = 1'b0; bus1.tx_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst tx_valid0", bus0.tx_valid, 0);
    check("rst tx_data0", bus0.tx_data, 0);
    check("rst mem_addr0", bus0.mem_addr, 0);
    check("rst mem_wdata0", bus0.mem_wdata, 0);
    check("rst mem_we0", bus0.mem_we, 0);
    check("rst busy0", busy0, 0);
    check("rst cmd_err0", cmd_err0, 0);
    check("rst busy1", busy1, 0);
    rst_n = 1'b1;
    step();

    // Write 0x5255 to 0x0005
    send_byte(0, "p");
    check("busy after p", busy0, 1);
    send_str(0, "00055255");
    check("wr mem_we", bus0.mem_we, 1);
    check("wr mem_addr", bus0.mem_addr, 32'h0005);
    check("wr mem_wdata", bus0.mem_wdata, 32'h5255);
    check("wr busy N+1", busy0, 1);
    step();
    check("wr mem_we N+2", bus0.mem_we, 0);
    check("wr busy N+2", busy0, 0);
    check("wr strobe count", we0, 1);

    // Read back from 0x0005
    q0.delete();
    send_str(0, "r0005");
    check("rd mem_addr N+1", bus0.mem_addr, 32'h0005);
    check("rd tx_valid N+1", bus0.tx_valid, 0);
    step();
    check("rd tx_valid N+2", bus0.tx_valid, 0);
    step();
    check("rd tx_valid N+3", bus0.tx_valid, 1);
    check("rd tx_data N+3", bus0.tx_data, "5");
    wait_bytes(0, 6);
    check_bytes(0, "5255\015\012");
    check("rd busy after reply", busy0, 0);

    // Malformed write: no memory write, "?" CR LF
    q0.delete();
    we_before = we0;
    send_str(0, "p00g");
    check("err cmd_err", cmd_err0, 1);
    check("err tx_valid", bus0.tx_valid, 1);
    check("err tx_data", bus0.tx_data, 8'h3F);
    step();
    check("err cmd_err pulse", cmd_err0, 0);
    wait_bytes(0, 3);
    check_bytes(0, "?\015\012");
    check("err no write", we0, we_before);
    check("err pulse count", err0, 1);
    check("err mem_addr held", bus0.mem_addr, 32'h0005);
    check("err mem_wdata held", bus0.mem_wdata, 32'h5255);

    q0.delete();
    send_str(0, "r0000");
    wait_bytes(0, 6);
    check_bytes(0, "0000\015\012");

    // Backpressure with dropped input during the reply
    send_str(0, "p00ABBEEF");
    check("bp wr mem_wdata", bus0.mem_wdata, 32'hBEEF);
    step();
    q0.delete();
    bus0.tx_ready = 1'b0;
    send_str(0, "r00AB");
    for (int i = 0; i < 10; i++) begin
      if (bus0.tx_valid === 1'b1) break;
      step();
    end
    check("bp tx_valid up", bus0.tx_valid, 1);
    send_byte(0, "p");
    send_byte(0, "1");
    held = bus0.tx_data;
    check("bp first byte", held, "B");
    for (int i = 0; i < 20; i++) begin
      check("bp tx_data stable", bus0.tx_data, held);
      check("bp tx_valid held", bus0.tx_valid, 1);
      step();
    end
    check("bp nothing sent", q0.size(), 0);
    bus0.tx_ready = 1'b1;
    wait_bytes(0, 6);
    check_bytes(0, "BEEF\015\012");
    check("bp busy after", busy0, 0);
    check("bp no cmd_err", err0, 1);

    // Stray byte in IDLE
    q0.delete();
    send_byte(0, "x");
    check("stray busy", busy0, 0);
    repeat (4) step();
    check("stray tx_valid", bus0.tx_valid, 0);
    check("stray no tx", q0.size(), 0);
    check("stray no cmd_err", err0, 1);

    // Narrow instance: mixed case, truncated address
    send_str(1, "PfFFabc");
    check("w1 mem_we", bus1.mem_we, 1);
    check("w1 mem_addr", bus1.mem_addr, 32'h3FF);
    check("w1 mem_wdata", bus1.mem_wdata, 32'hABC);
    step();
    check("w1 busy", busy1, 0);
    q1.delete();
    send_str(1, "RfFF");
    check("r1 mem_addr", bus1.mem_addr, 32'h3FF);
    check("r1 tx_valid N+1", bus1.tx_valid, 0);
    step();
    step();
    check("r1 tx_valid N+3", bus1.tx_valid, 0);
    step();
    check("r1 tx_valid N+4", bus1.tx_valid, 1);
    wait_bytes(1, 5);
    check_bytes(1, "ABC\015\012");
    check("r1 no cmd_err", err1, 0);

    // Asynchronous reset mid-command
    send_str(0, "p00");
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst busy", busy0, 0);
    check("mid rst mem_addr", bus0.mem_addr, 0);
    check("mid rst mem_wdata", bus0.mem_wdata, 0);
    check("mid rst tx_valid", bus0.tx_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    we_before = we0;
    send_str(0, "p00010001");
    check("post rst mem_we", bus0.mem_we, 1);
    check("post rst mem_addr", bus0.mem_addr, 32'h0001);
    check("post rst mem_wdata", bus0.mem_wdata, 32'h0001);
    step();
    check("post rst one write", we0, we_before + 1);
    q0.delete();
    send_str(0, "r0001");
    wait_bytes(0, 6);
    check_bytes(0, "0001\015\012");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
